// File: rtl/hrm_io_stream.sv
// hrm_io_stream - table-driven INBOX feeder, OUTBOX drainer and watchdog for the hrmcpu ports.
// The feed replays {delay, data} entries; the drain and the watchdog run independently of it.
module hrm_io_stream #(
  parameter int DATA_W    = 8,
  parameter int DELAY_W   = 10,
  parameter int AW        = 6,
  parameter     STIM_FILE = "INBOX.hex",
  parameter int POP_GAP   = 1,
  parameter int TIMEOUT   = 5000,
  parameter int TW        = 16
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              start,
  input  logic [AW:0]       stim_len,
  input  logic              drain_en,
  input  logic              in_full,
  output logic [DATA_W-1:0] in_data,
  output logic              in_wr,
  input  logic              out_empty,
  input  logic [DATA_W-1:0] out_data,
  output logic              out_rd,
  output logic              cap_valid,
  output logic [DATA_W-1:0] cap_data,
  output logic [15:0]       cap_count,
  output logic              busy,
  output logic              feed_done,
  output logic              timeout
);

  localparam int EW = DELAY_W + DATA_W;
  localparam int GW = (POP_GAP > 0) ? $clog2(POP_GAP + 1) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_PUSH, S_DONE} state_t;

  logic [EW-1:0]      mem [0:(1<<AW)-1];
  state_t             state;
  logic [AW-1:0]      ptr;
  logic [AW:0]        len;
  logic [DELAY_W-1:0] dly_cnt;
  logic [DATA_W-1:0]  data_reg;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      wd_cnt;
  logic               wd_armed;

  // The table read lands directly in dly_cnt/data_reg, so LOAD is the read cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      len      <= '0;
      dly_cnt  <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len   <= stim_len;
            ptr   <= '0;
            state <= (stim_len == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          {dly_cnt, data_reg} <= mem[ptr];
          state               <= S_WAIT;
        end
        S_WAIT: begin
          if (dly_cnt == '0) state <= S_PUSH;
          else               dly_cnt <= dly_cnt - 1'b1;
        end
        S_PUSH: begin
          if (!in_full) begin
            ptr   <= ptr + 1'b1;
            state <= ({1'b0, ptr} == len - 1'b1) ? S_DONE : S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_data   = data_reg;
  assign in_wr     = (state == S_PUSH) & ~in_full;
  assign busy      = (state == S_LOAD) | (state == S_WAIT) | (state == S_PUSH);
  assign feed_done = (state == S_DONE);

  assign out_rd = drain_en & ~out_empty & (gap_cnt == '0);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      gap_cnt   <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_count <= '0;
    end else begin
      cap_valid <= out_rd;
      if (out_rd) begin
        cap_data <= out_data;
        gap_cnt  <= GW'(POP_GAP);
        if (cap_count != 16'hFFFF) cap_count <= cap_count + 1'b1;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // start outranks expiry; the flag only informs, it never stops either engine.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt   <= '0;
      wd_armed <= 1'b0;
      timeout  <= 1'b0;
    end else if (start) begin
      wd_cnt   <= '0;
      timeout  <= 1'b0;
      wd_armed <= (TIMEOUT != 0);
    end else if (wd_armed) begin
      if (wd_cnt == WD_LAST) begin
        timeout  <= 1'b1;
        wd_armed <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hrm_io_stream.sv
// tb/tb_hrm_io_stream.sv - scoreboard bench for hrm_io_stream feed, drain and watchdog.
module tb_hrm_io_stream;

  typedef struct {
    int         rel;
    logic [7:0] data;
  } push_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] stim_len = '0;
  logic       drain_en = 1'b1;
  logic       in_full = 1'b0;
  logic [7:0] in_data;
  logic       in_wr;
  logic       out_empty;
  logic [7:0] out_data;
  logic       out_rd;
  logic       cap_valid;
  logic [7:0] cap_data;
  logic [15:0] cap_count;
  logic       busy, feed_done, timeout;

  logic       start0 = 1'b0;
  logic [6:0] stim_len0 = '0;
  logic       in_full0 = 1'b0;
  logic       drain_en0 = 1'b1;
  logic [7:0] in_data0;
  logic       in_wr0;
  logic       out_empty0;
  logic [7:0] out_data0;
  logic       out_rd0;
  logic       cap_valid0;
  logic [7:0] cap_data0;
  logic [15:0] cap_count0;
  logic       busy0, feed_done0, timeout0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_rd1 = -1;
  int last_rd0 = -1;

  push_t      fq[$];
  logic [7:0] cq1[$];
  logic [7:0] cq0[$];

  logic [7:0] ob1 [0:15];
  logic [7:0] ob0 [0:15];
  int h1 = 0, t1 = 0, h0 = 0, t0 = 0;

  hrm_io_stream #(.DATA_W(8), .DELAY_W(10), .AW(6), .STIM_FILE(""),
                  .POP_GAP(1), .TIMEOUT(20), .TW(16)) dut (
    .clk(clk), .i_rst(i_rst), .start(start), .stim_len(stim_len), .drain_en(drain_en),
    .in_full(in_full), .in_data(in_data), .in_wr(in_wr), .out_empty(out_empty),
    .out_data(out_data), .out_rd(out_rd), .cap_valid(cap_valid), .cap_data(cap_data),
    .cap_count(cap_count), .busy(busy), .feed_done(feed_done), .timeout(timeout));

  hrm_io_stream #(.DATA_W(8), .DELAY_W(10), .AW(6), .STIM_FILE(""),
                  .POP_GAP(0), .TIMEOUT(0), .TW(16)) dut0 (
    .clk(clk), .i_rst(i_rst), .start(start0), .stim_len(stim_len0), .drain_en(drain_en0),
    .in_full(in_full0), .in_data(in_data0), .in_wr(in_wr0), .out_empty(out_empty0),
    .out_data(out_data0), .out_rd(out_rd0), .cap_valid(cap_valid0), .cap_data(cap_data0),
    .cap_count(cap_count0), .busy(busy0), .feed_done(feed_done0), .timeout(timeout0));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // First-word fall-through OUTBOX models.
  always @(posedge clk) begin
    if (out_rd)  h1 <= h1 + 1;
    if (out_rd0) h0 <= h0 + 1;
  end
  assign out_empty  = (h1 == t1);
  assign out_data   = ob1[h1 % 16];
  assign out_empty0 = (h0 == t0);
  assign out_data0  = ob0[h0 % 16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - start_cyc < n) step();
  endtask

  task automatic do_start(input logic [6:0] len);
    start     = 1'b1;
    stim_len  = len;
    start_cyc = cyc;
    step();
    start     = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUTs present a push or a capture.
  always @(negedge clk) begin
    push_t      e;
    logic [7:0] c;
    if (in_wr) begin
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL push_unexpected act=%0h rel=%0d", in_data, cyc - start_cyc);
      end else begin
        e = fq.pop_front();
        if (in_data !== e.data || (cyc - start_cyc) != e.rel) begin
          bad++;
          $display("FAIL push act=%0h@%0d exp=%0h@%0d", in_data, cyc - start_cyc, e.data, e.rel);
        end
      end
    end
    if (cap_valid) begin
      total++;
      if (cq1.size() == 0) begin
        bad++;
        $display("FAIL cap1_unexpected act=%0h", cap_data);
      end else begin
        c = cq1.pop_front();
        if (cap_data !== c) begin
          bad++;
          $display("FAIL cap1 act=%0h exp=%0h", cap_data, c);
        end
      end
    end
    if (cap_valid0) begin
      total++;
      if (cq0.size() == 0) begin
        bad++;
        $display("FAIL cap0_unexpected act=%0h", cap_data0);
      end else begin
        c = cq0.pop_front();
        if (cap_data0 !== c) begin
          bad++;
          $display("FAIL cap0 act=%0h exp=%0h", cap_data0, c);
        end
      end
    end
    if (out_rd) begin
      if (last_rd1 >= 0) check("rd_gap1", cyc - last_rd1, 2);
      last_rd1 = cyc;
    end
    if (out_rd0) begin
      if (last_rd0 >= 0) check("rd_gap0", cyc - last_rd0, 1);
      last_rd0 = cyc;
    end
    if (out_empty)  check("rd_when_empty1", {31'd0, out_rd}, 0);
    if (out_empty0) check("rd_when_empty0", {31'd0, out_rd0}, 0);
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit act=running exp=finished");
    $fatal(1);
  end

  initial begin
    dut.mem[0] = 18'h00005;
    dut.mem[1] = 18'h0020A;
    dut.mem[2] = 18'h000FF;
    #2;
    check("rst_flags", {26'd0, in_wr, out_rd, cap_valid, busy, feed_done, timeout}, 0);
    check("rst_data", {8'd0, in_data, cap_data, 8'd0}, 0);
    check("rst_count", {16'd0, cap_count}, 0);
    step(); step();
    i_rst = 1'b0;
    step();

    // Feed, no backpressure.
    fq.push_back('{3, 8'h05});
    fq.push_back('{8, 8'h0A});
    fq.push_back('{11, 8'hFF});
    do_start(7'd3);
    check("t1_busy", {31'd0, busy}, 1);
    wait_rel(11);
    check("t1_done_early", {31'd0, feed_done}, 0);
    wait_rel(12);
    check("t1_done", {31'd0, feed_done}, 1);
    check("t1_busy_after", {31'd0, busy}, 0);
    check("t1_q_empty", fq.size(), 0);

    // Feed with in_full held over cycles 3..6.
    fq.push_back('{7, 8'h05});
    fq.push_back('{12, 8'h0A});
    fq.push_back('{15, 8'hFF});
    do_start(7'd3);
    check("t2_done_cleared", {31'd0, feed_done}, 0);
    wait_rel(2);
    in_full = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      wait_rel(k);
      check("t2_stall_data", {24'd0, in_data}, 32'h05);
      check("t2_stall_wr", {31'd0, in_wr}, 0);
    end
    wait_rel(7);
    in_full = 1'b0;
    wait_rel(15);
    check("t2_done_early", {31'd0, feed_done}, 0);
    wait_rel(16);
    check("t2_done", {31'd0, feed_done}, 1);
    check("t2_q_empty", fq.size(), 0);

    // Drain with POP_GAP=1.
    ob1[0] = 8'h11; ob1[1] = 8'h22; ob1[2] = 8'h33;
    cq1.push_back(8'h11); cq1.push_back(8'h22); cq1.push_back(8'h33);
    last_rd1 = -1;
    t1 = 3;
    for (int k = 0; k < 20 && cap_count != 16'd3; k++) step();
    step(); step();
    check("t3_count", {16'd0, cap_count}, 3);
    check("t3_q_empty", cq1.size(), 0);

    // Drain with POP_GAP=0.
    ob0[0] = 8'h41; ob0[1] = 8'h42; ob0[2] = 8'h43; ob0[3] = 8'h44;
    cq0.push_back(8'h41); cq0.push_back(8'h42); cq0.push_back(8'h43); cq0.push_back(8'h44);
    last_rd0 = -1;
    t0 = 4;
    for (int k = 0; k < 20 && cap_count0 != 16'd4; k++) step();
    step(); step();
    check("t4_count", {16'd0, cap_count0}, 4);
    check("t4_q_empty", cq0.size(), 0);

    // Watchdog against a long-delay entry.
    dut.mem[0] = 18'h3E877;
    do_start(7'd1);
    check("t5_cleared", {31'd0, timeout}, 0);
    wait_rel(20);
    check("t5_before", {31'd0, timeout}, 0);
    wait_rel(21);
    check("t5_set", {31'd0, timeout}, 1);
    wait_rel(30);
    check("t5_sticky", {31'd0, timeout}, 1);
    check("t5_busy", {31'd0, busy}, 1);

    // Asynchronous reset in the middle of WAIT.
    #3;
    i_rst = 1'b1;
    #1;
    check("t6_flags", {26'd0, in_wr, out_rd, cap_valid, busy, feed_done, timeout}, 0);
    check("t6_data", {8'd0, in_data, cap_data, 8'd0}, 0);
    check("t6_count", {16'd0, cap_count}, 0);
    step(); step();
    i_rst = 1'b0;
    step();
    do_start(7'd0);
    check("t6_done", {31'd0, feed_done}, 1);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_wr", {31'd0, in_wr}, 0);
    wait_rel(25);
    check("t6_wd_set", {31'd0, timeout}, 1);
    do_start(7'd0);
    check("t6_wd_clear", {31'd0, timeout}, 0);
    check("t6_done_again", {31'd0, feed_done}, 1);
    step(); step();
    check("end_fq", fq.size(), 0);
    check("end_cq", cq1.size() + cq0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
